// File: rtl/ppl_ctrl_pkg.sv
// Shared encodings for the pipeline control unit: hold/clear bus codes and
// interrupt FSM states (mirrors the legacy para.v definitions).
package ppl_ctrl_pkg;

    localparam int HOLDBUS  = 3;
    localparam int CLEARBUS = 3;

    typedef logic [HOLDBUS-1:0]  hold_t;
    typedef logic [CLEARBUS-1:0] clear_t;

    localparam hold_t Hold_None = 3'd0;
    localparam hold_t Hold_PC   = 3'd1;
    localparam hold_t Hold_IF   = 3'd2;
    localparam hold_t Hold_ID   = 3'd3;
    localparam hold_t Hold_EX   = 3'd4;
    localparam hold_t Hold_PPL  = 3'd5;

    localparam clear_t Clear_None = 3'd0;
    localparam clear_t Clear_IF   = 3'd1;
    localparam clear_t Clear_ID   = 3'd2;
    localparam clear_t Clear_EX   = 3'd3;
    localparam clear_t Clear_PPL  = 3'd4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PEND = 2'd1;
    localparam logic [1:0] S_ISR  = 2'd2;

endpackage

// File: rtl/ppl_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the pipeline control
// unit (slave): hazard/jump/interrupt inputs and stall/flush/redirect outputs.
interface ppl_ctrl_if import ppl_ctrl_pkg::*; #(
    parameter int ADDR_W = 16,
    parameter int REG_W  = 3
);
    logic              mem_busy;
    logic              ID_valid;
    logic [ADDR_W-1:0] ID_inst_addr;
    logic [REG_W-1:0]  ID_rs1;
    logic [REG_W-1:0]  ID_rs2;
    logic              ID_rs1_used;
    logic              ID_rs2_used;
    logic [REG_W-1:0]  EX_rd;
    logic              EX_RegWe;
    logic              EX_RWSel;
    logic              EX_jump_taken;
    logic [ADDR_W-1:0] EX_jump_addr;
    logic              EX_mret;
    logic              int_req;
    logic [ADDR_W-1:0] int_vector;

    hold_t             hold_flag;
    clear_t            clear_flag;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_addr;
    logic              int_ack;
    logic              int_active;
    logic [ADDR_W-1:0] epc;

    modport master (
        output mem_busy, ID_valid, ID_inst_addr, ID_rs1, ID_rs2, ID_rs1_used,
               ID_rs2_used, EX_rd, EX_RegWe, EX_RWSel, EX_jump_taken,
               EX_jump_addr, EX_mret, int_req, int_vector,
        input  hold_flag, clear_flag, pc_load, pc_load_addr, int_ack,
               int_active, epc
    );

    modport slave (
        input  mem_busy, ID_valid, ID_inst_addr, ID_rs1, ID_rs2, ID_rs1_used,
               ID_rs2_used, EX_rd, EX_RegWe, EX_RWSel, EX_jump_taken,
               EX_jump_addr, EX_mret, int_req, int_vector,
        output hold_flag, clear_flag, pc_load, pc_load_addr, int_ack,
               int_active, epc
    );

endinterface

// File: rtl/ppl_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the
// instruction in ID.
module hazard_detect #(
    parameter int REG_W = 3
) (
    input  logic             ex_reg_we,
    input  logic             ex_rw_sel,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs1,
    input  logic             id_rs1_used,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs2_used,
    output logic             load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_rs1_used && (id_rs1 == ex_rd);
    assign rs2_hit  = id_rs2_used && (id_rs2 == ex_rd);
    assign load_use = ex_reg_we && ex_rw_sel && (rs1_hit || rs2_hit);

endmodule

// File: rtl/ppl_ctrl.sv
// Pipeline control unit: prioritised stall/flush/redirect decision plus the
// interrupt sequencer. Interrupt support is compiled in with `define PPL_INT_EN.
module ppl_ctrl import ppl_ctrl_pkg::*; #(
    parameter int ADDR_W = 16,
    parameter int REG_W  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    ppl_ctrl_if.slave   bus
);

    logic              load_use;
    logic              redirect_ok;
    logic              mret_fire;
    logic              accept;
    logic [ADDR_W-1:0] epc_q;
    logic [ADDR_W-1:0] vec_q;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .ex_reg_we   (bus.EX_RegWe),
        .ex_rw_sel   (bus.EX_RWSel),
        .ex_rd       (bus.EX_rd),
        .id_rs1      (bus.ID_rs1),
        .id_rs1_used (bus.ID_rs1_used),
        .id_rs2      (bus.ID_rs2),
        .id_rs2_used (bus.ID_rs2_used),
        .load_use    (load_use)
    );

    // Rows 3/4 may only fire when neither a memory stall nor a jump claims the cycle.
    assign redirect_ok = !bus.mem_busy && !bus.EX_jump_taken;

`ifdef PPL_INT_EN
    logic [1:0] state;
    logic [1:0] state_nxt;

    assign mret_fire = redirect_ok && bus.EX_mret && (state == S_ISR);
    assign accept    = redirect_ok && bus.ID_valid && (state == S_PEND);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.int_req) state_nxt = S_PEND;
            S_PEND:  if (accept)      state_nxt = S_ISR;
            S_ISR:   if (mret_fire)   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The request is latched in IDLE even during a memory stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            epc_q <= '0;
            vec_q <= '0;
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE) && bus.int_req) vec_q <= bus.int_vector;
            if (accept)                           epc_q <= bus.ID_inst_addr;
        end
    end

    assign bus.int_active = (state == S_ISR);
    assign bus.int_ack    = accept && rst_n;
    assign bus.epc        = epc_q;
`else
    logic unused_int;

    assign unused_int     = ^{bus.int_req, bus.EX_mret, bus.int_vector,
                              bus.ID_valid, bus.ID_inst_addr, clk};
    assign mret_fire      = 1'b0;
    assign accept         = 1'b0;
    assign epc_q          = '0;
    assign vec_q          = '0;
    assign bus.int_active = 1'b0;
    assign bus.int_ack    = 1'b0;
    assign bus.epc        = '0;
`endif

    // Outputs are forced to their idle codes while reset is held.
    always_comb begin
        bus.hold_flag    = Hold_None;
        bus.clear_flag   = Clear_None;
        bus.pc_load      = 1'b0;
        bus.pc_load_addr = '0;
        if (!rst_n) begin
            bus.hold_flag = Hold_None;
        end else if (bus.mem_busy) begin
            bus.hold_flag = Hold_PPL;
        end else if (bus.EX_jump_taken) begin
            bus.pc_load      = 1'b1;
            bus.pc_load_addr = bus.EX_jump_addr;
            bus.clear_flag   = Clear_PPL;
        end else if (mret_fire) begin
            bus.pc_load      = 1'b1;
            bus.pc_load_addr = epc_q;
            bus.clear_flag   = Clear_PPL;
        end else if (accept) begin
            bus.pc_load      = 1'b1;
            bus.pc_load_addr = vec_q;
            bus.clear_flag   = Clear_PPL;
        end else if (load_use) begin
            bus.hold_flag  = Hold_ID;
            bus.clear_flag = Clear_EX;
        end
    end

endmodule

// File: doc/ppl_ctrl.md
# ppl_ctrl

Pipeline control unit for the interrupt-capable 16-bit pipelined core. It is the producer of the `hold_flag` and `clear_flag` buses that every pipeline register (IF/ID, ID/EX, …) decodes. It detects memory stalls, taken jumps, load-use hazards and interrupt entry/return, and drives the matching stall/flush codes together with PC redirects. It holds the interrupt sequencing state (pending request, in-ISR flag, saved return address).

## Interface
Parameters:
- `ADDR_W`, 16, address/data width (equals `CPU_WIDTH`)
- `REG_W`, 3, register index width

Ports (clock and reset first). Clock is `clk`; reset is `rst_n`, **asynchronous, active-low**.
- `clk` in 1: core clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `mem_busy` in 1: data memory not ready this cycle
- `ID_valid` in 1: ID stage holds a real instruction (not a bubble)
- `ID_inst_addr` in ADDR_W: address of the instruction in ID
- `ID_rs1`, `ID_rs2` in REG_W: source register indices read in ID
- `ID_rs1_used`, `ID_rs2_used` in 1: the matching source is actually read
- `EX_rd` in REG_W: destination register of the instruction in EX
- `EX_RegWe` in 1: EX instruction writes a register
- `EX_RWSel` in 1: EX write-back value comes from memory (load)
- `EX_jump_taken` in 1: branch/jump resolved taken in EX
- `EX_jump_addr` in ADDR_W: its target address
- `EX_mret` in 1: return-from-interrupt instruction in EX
- `int_req` in 1: external interrupt request (level or single-cycle pulse)
- `int_vector` in ADDR_W: ISR entry address, sampled with the request
- `hold_flag` out HOLDBUS: stall code
- `clear_flag` out CLEARBUS: flush code
- `pc_load` out 1: PC takes `pc_load_addr` at the next edge
- `pc_load_addr` out ADDR_W: PC redirect target
- `int_ack` out 1: one-cycle pulse on ISR entry
- `int_active` out 1: core is executing an ISR
- `epc` out ADDR_W: saved return address

## Operation
- State register: IDLE, PEND, ISR.
  - IDLE: `int_req` latches the request and the vector, then goes to PEND.
  - PEND: on accept, goes to ISR.
  - ISR: on `EX_mret`, goes to IDLE.
  - `int_req` is ignored while in ISR (no nesting). A request is never lost while in PEND.
- Per-cycle decision, highest priority first. Only one row fires per cycle.
  1. `mem_busy`: `hold_flag=Hold_PPL`, clear none, no `pc_load`, all state frozen. A request arriving in IDLE is still latched.
  2. `EX_jump_taken`: `pc_load`, addr=`EX_jump_addr`, `clear_flag=Clear_PPL`. PEND is kept.
  3. `EX_mret` while in ISR: `pc_load`, addr=`epc`, `Clear_PPL`, `int_active` drops next edge. `EX_mret` in IDLE or PEND is a no-op.
  4. State is PEND and `ID_valid`:
     - `pc_load` with the latched vector, `Clear_PPL`, `int_ack=1`.
     - `epc<=ID_inst_addr`; the flushed ID instruction re-executes after return.
  5. Load-use hazard: `EX_RegWe & EX_RWSel & ((ID_rs1_used & ID_rs1==EX_rd) | (ID_rs2_used & ID_rs2==EX_rd))`. Response: `hold_flag=Hold_ID` (PC and IF/ID freeze) plus `clear_flag=Clear_EX` (bubble into ID/EX).
  6. Otherwise `Hold_None` / `Clear_None`.
- `Clear_PPL` flushes IF/ID and ID/EX only; the instruction in EX always completes.

## Timing
- `hold_flag`, `clear_flag`, `pc_load`, `pc_load_addr` and `int_ack` are combinational from the current inputs and state. Consumers sample them at the same rising edge.
- State, `epc`, latched vector and `int_active` are registered.
- Latency:
  - request-to-entry is at least 1 cycle after the request edge (IDLE→PEND→accept).
  - a stalled entry waits for `mem_busy=0`, no jump, and `ID_valid=1`.
- Reset (async, immediate):
  - state IDLE, `epc=0`, `int_active=0`
  - `hold_flag=Hold_None`, `clear_flag=Clear_None`
  - `pc_load=0`, `pc_load_addr=0`, `int_ack=0`
- Reset mid-ISR discards the pending request and the return address.
- Jump and interrupt in the same cycle: the jump wins, and the interrupt enters on a later cycle whose ID holds the jump target.

## Configuration
- `PPL_INT_EN` defined: interrupt FSM, `epc` and the mret path are compiled in.
- `PPL_INT_EN` undefined: `int_req` and `EX_mret` are ignored; `int_ack`, `int_active` and `epc` are tied 0. Only priorities 1, 2, 5 and 6 remain.

## Structure
- `para.v` carries `HOLDBUS` [2:0] and `CLEARBUS` [2:0].
- Hold codes: `Hold_None`=0, `Hold_PC`=1, `Hold_IF`=2, `Hold_ID`=3, `Hold_EX`=4, `Hold_PPL`=5.
- Clear codes: `Clear_None`=0, `Clear_IF`=1, `Clear_ID`=2, `Clear_EX`=3, `Clear_PPL`=4.
- The state encodings are also defined in `para.v`.
- One sub-module, `hazard_detect`: combinational load-use compare, instanced once.

## Test plan
- Load r3, then ID reads r3 (`ID_rs1=3`, `ID_rs1_used=1`, `EX_rd=3`, `EX_RWSel=1`) → `hold_flag=3`, `clear_flag=3` for exactly 1 cycle.
- `EX_jump_taken=1`, `EX_jump_addr=16'h0040` → `pc_load=1`, `pc_load_addr=16'h0040`, `clear_flag=4`. A simultaneous load-use is suppressed.
- `mem_busy=1` for 3 cycles with a jump asserted → `hold_flag=5` for 3 cycles, no `pc_load`. The jump is acted on in the first cycle with `mem_busy=0`.
- 1-cycle `int_req` pulse, `int_vector=16'h0100`, `ID_inst_addr=16'h0022` → next cycle: `pc_load` to 16'h0100, `int_ack` pulse, `epc=16'h0022`, `int_active=1`.
- In ISR, second `int_req` → ignored. `EX_mret` → `pc_load_addr=16'h0022`, `clear_flag=4`, `int_active=0` next cycle.
- `rst_n` low in ISR → all outputs are zero/None immediately. After release, `EX_mret` does not redirect.
